// File: rtl/heading_motion_controller.sv
// heading_motion_controller: yaw-closed-loop executor for forward/backward/turn commands driving motor_out
module heading_motion_controller #(
  parameter int TURN_ANGLE = 90,
  parameter int TURN_TOL = 2,
  parameter int DEADBAND = 3,
  parameter logic [15:0] CORR_CYCLES = 16'd5000,
  parameter logic [31:0] SETTLE_CYCLES = 32'd100000,
  parameter logic [31:0] TURN_TIMEOUT = 32'd50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] yaw,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd,
  input  logic [31:0] run_time,
  input  logic        abort,
  output logic        cmd_ready,
  output logic [2:0]  motor_out,
  output logic        busy,
  output logic        done,
  output logic        fault
);
  typedef enum logic [2:0] {IDLE, LATCH, FWD, CORR, BACK, TURN, SETTLE} state_t;
  localparam logic signed [16:0] TA = 17'(TURN_ANGLE);
  localparam logic signed [16:0] TT = 17'(TURN_TOL);
  localparam logic signed [16:0] DB = 17'(DEADBAND);
  state_t state, state_n;
  logic [1:0] cmd_r;
  logic [31:0] run_r, cnt, run_cnt;
  logic [15:0] ref_r;
  logic signed [16:0] target, e_raw, e;
  logic [2:0] mot_n;
  logic no_done, run_end, tmo, stop;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign e_raw = $signed({1'b0, yaw}) - target;
  assign e = (e_raw > 17'sd180) ? e_raw - 17'sd360 : (e_raw < -17'sd180) ? e_raw + 17'sd360 : e_raw;
  assign run_end = run_cnt == run_r - 32'd1;
  assign tmo = state == TURN && cnt == TURN_TIMEOUT - 32'd1;
  assign stop = abort && state != IDLE;
  // next state and next motor code; abort overrides everything outside IDLE
  always_comb begin
    state_n = state;
    mot_n = motor_out;
    case (state)
      IDLE: state_n = cmd_valid ? LATCH : IDLE;
      LATCH: begin
        state_n = cmd_r[1] ? TURN : (run_r == 32'd0) ? SETTLE : cmd_r[0] ? BACK : FWD;
        mot_n = (!cmd_r[1] && run_r == 32'd0) ? 3'd4 : {1'b0, cmd_r};
      end
      FWD: begin
        state_n = run_end ? SETTLE : (e > DB || e < -DB) ? CORR : FWD;
        mot_n = run_end ? 3'd4 : (e > DB) ? 3'd2 : (e < -DB) ? 3'd3 : 3'd0;
      end
      CORR: begin
        state_n = run_end ? SETTLE : (cnt == 32'(CORR_CYCLES) - 32'd1) ? FWD : CORR;
        mot_n = run_end ? 3'd4 : (cnt == 32'(CORR_CYCLES) - 32'd1) ? 3'd0 : motor_out;
      end
      BACK: begin
        state_n = (cnt == run_r - 32'd1) ? SETTLE : BACK;
        mot_n = (cnt == run_r - 32'd1) ? 3'd4 : 3'd1;
      end
      TURN: begin
        state_n = (tmo || (e <= TT && e >= -TT)) ? SETTLE : TURN;
        mot_n = (state_n == SETTLE) ? 3'd4 : motor_out;
      end
      SETTLE: begin
        state_n = (cnt == SETTLE_CYCLES - 32'd1) ? IDLE : SETTLE;
        mot_n = 3'd4;
      end
      default: begin
        state_n = IDLE;
        mot_n = 3'd4;
      end
    endcase
    if (stop) begin
      state_n = SETTLE;
      mot_n = 3'd4;
    end
  end
  // state, counters, latched command and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      motor_out <= 3'd4;
      done <= 1'b0;
      fault <= 1'b0;
      no_done <= 1'b0;
      cnt <= 32'd0;
      run_cnt <= 32'd0;
      cmd_r <= 2'd0;
      run_r <= 32'd0;
      ref_r <= 16'd0;
      target <= 17'sd0;
    end else begin
      state <= state_n;
      motor_out <= mot_n;
      cnt <= (state_n != state) ? 32'd0 : cnt + 32'd1;
      run_cnt <= ((state == FWD || state == CORR) && (state_n == FWD || state_n == CORR)) ? run_cnt + 32'd1 : 32'd0;
      done <= state == SETTLE && state_n == IDLE && !no_done;
      if (state == IDLE && cmd_valid) begin
        cmd_r <= cmd;
        run_r <= run_time;
        ref_r <= yaw;
        fault <= 1'b0;
        no_done <= 1'b0;
      end
      if (state == LATCH)
        target <= (cmd_r == 2'd3) ? $signed({1'b0, ref_r}) + TA : (cmd_r == 2'd2) ? $signed({1'b0, ref_r}) - TA : $signed({1'b0, ref_r});
      if (tmo && !abort) begin
        fault <= 1'b1;
        no_done <= 1'b1;
      end
      if (stop)
        no_done <= 1'b1;
    end
  end
endmodule
